// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for the multi-port register file: three read ports, two write
// ports and the busy-scoreboard controls/status. The CPU side uses "master",
// the register file uses "slave".
interface regfile_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int BE_W = DATA_W / 8;

    // read ports
    logic [ADDR_W-1:0] ra0;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rbusy0;
    logic              rbusy1;
    logic              rbusy2;

    // write port A: single-cycle ALU/load path with byte enables
    logic              wa_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [BE_W-1:0]   wa_be;
    logic [DATA_W-1:0] wa_data;

    // write port B: long-latency MUL/DIV writeback, full word
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    // scoreboard issue and status
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic [ADDR_W:0]   busy_cnt;
    logic              busy_any;

    modport master (
        output ra0, ra1, ra2,
        input  rd0, rd1, rd2, rbusy0, rbusy1, rbusy2,
        output wa_en, wa_addr, wa_be, wa_data,
        output wb_en, wb_addr, wb_data,
        output sb_set, sb_addr,
        input  busy_cnt, busy_any
    );

    modport slave (
        input  ra0, ra1, ra2,
        output rd0, rd1, rd2, rbusy0, rbusy1, rbusy2,
        input  wa_en, wa_addr, wa_be, wa_data,
        input  wb_en, wb_addr, wb_data,
        input  sb_set, sb_addr,
        output busy_cnt, busy_any
    );

endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port general-purpose register file for the pipelined core.
// Three combinational read ports with per-byte write-through bypass from
// both write ports (port A byte-enabled, port B full word), plus a
// per-register busy scoreboard for long-latency ops and a running count of
// busy registers for the decode stall logic.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_mp_sb_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BE_W  = DATA_W / 8;
    localparam int NRP   = 3;
    localparam bit ZR    = (ZERO_REG != 0);

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    // architectural state
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_cnt;

    // qualified write / issue strobes (register 0 masked when hardwired)
    logic w_wa_we;
    logic w_wb_we;
    logic w_sb_we;
    logic w_cnt_inc;
    logic w_cnt_dec;
    logic [DEPTH-1:0] w_busy_next;

    // read port vectors
    logic [ADDR_W-1:0] w_ra    [NRP];
    logic [DATA_W-1:0] w_rd    [NRP];
    logic              w_rbusy [NRP];

    assign w_wa_we = bus.wa_en  && !(ZR && bus.wa_addr == '0);
    assign w_wb_we = bus.wb_en  && !(ZR && bus.wb_addr == '0);
    assign w_sb_we = bus.sb_set && !(ZR && bus.sb_addr == '0);

    // A set on an idle register adds one; a clear of a busy register removes
    // one unless a set to the same register in the same cycle keeps it busy.
    assign w_cnt_inc = w_sb_we && !r_busy[bus.sb_addr];
    assign w_cnt_dec = w_wb_we && r_busy[bus.wb_addr] &&
                       !(w_sb_we && bus.sb_addr == bus.wb_addr);

    // Register array update: port B word first, port A enabled bytes on top.
    // NOTE: every register is cleared by the async reset because the reset
    // state (all zero) is architecturally visible; this forces flops, not RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (w_wa_we && bus.wa_addr == ADDR_W'(i) && bus.wa_be[b]) begin
                        r_mem[i][8*b +: 8] <= bus.wa_data[8*b +: 8];
                    end else if (w_wb_we && bus.wb_addr == ADDR_W'(i)) begin
                        r_mem[i][8*b +: 8] <= bus.wb_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Next busy vector: clear on writeback, then set on issue so set wins.
    // NOTE: combinational blocks use blocking '=' and assign a full default
    // first; the later assignment overriding the earlier one is the priority.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wb_we) begin
            w_busy_next[bus.wb_addr] = 1'b0;
        end
        if (w_sb_we) begin
            w_busy_next[bus.sb_addr] = 1'b1;
        end
    end

    // Busy scoreboard state.
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Busy counter: at most one set and one clear per cycle, so it moves by
    // at most one and cannot leave 0..DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_cnt <= '0;
        end else if (w_cnt_inc && !w_cnt_dec) begin
            r_busy_cnt <= r_busy_cnt + CNT_ONE;
        end else if (w_cnt_dec && !w_cnt_inc) begin
            r_busy_cnt <= r_busy_cnt - CNT_ONE;
        end
    end

    assign w_ra[0] = bus.ra0;
    assign w_ra[1] = bus.ra1;
    assign w_ra[2] = bus.ra2;

    // Read ports: per-byte bypass, port A (enabled byte) over port B over
    // stored data; hardwired zero register and reset force zeros.
    always_comb begin
        for (int p = 0; p < NRP; p++) begin
            w_rd[p]    = r_mem[w_ra[p]];
            w_rbusy[p] = r_busy[w_ra[p]] && !(w_wb_we && bus.wb_addr == w_ra[p]);
            for (int b = 0; b < BE_W; b++) begin
                if (w_wa_we && bus.wa_addr == w_ra[p] && bus.wa_be[b]) begin
                    w_rd[p][8*b +: 8] = bus.wa_data[8*b +: 8];
                end else if (w_wb_we && bus.wb_addr == w_ra[p]) begin
                    w_rd[p][8*b +: 8] = bus.wb_data[8*b +: 8];
                end
            end
            if (rst || (ZR && w_ra[p] == '0)) begin
                w_rd[p]    = '0;
                w_rbusy[p] = 1'b0;
            end
        end
    end

    assign bus.rd0      = w_rd[0];
    assign bus.rd1      = w_rd[1];
    assign bus.rd2      = w_rd[2];
    assign bus.rbusy0   = w_rbusy[0];
    assign bus.rbusy1   = w_rbusy[1];
    assign bus.rbusy2   = w_rbusy[2];
    assign bus.busy_cnt = r_busy_cnt;
    assign bus.busy_any = (r_busy_cnt != '0);

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (DATA_W=32, ADDR_W=5, ZERO_REG=1).
// A table of single-cycle vectors is applied in order; each vector's
// expected outputs go into a scoreboard queue when it is driven and are
// popped and compared once the combinational outputs have settled.
// Hand-written sequences cover reset, counter saturation and mid-write reset.
module tb_regfile_mp_sb;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_mp_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wa_en;
        logic [AW-1:0] wa_addr;
        logic [3:0]    wa_be;
        logic [DW-1:0] wa_data;
        logic          wb_en;
        logic [AW-1:0] wb_addr;
        logic [DW-1:0] wb_data;
        logic          sb_set;
        logic [AW-1:0] sb_addr;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] e_rd0;
        logic [DW-1:0] e_rd1;
        logic          e_rbusy0;
        logic [AW:0]   e_cnt;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        logic          rbusy0;
        logic [AW:0]   cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic wa_en, input logic [AW-1:0] wa_addr, input logic [3:0] wa_be,
        input logic [DW-1:0] wa_data,
        input logic wb_en, input logic [AW-1:0] wb_addr, input logic [DW-1:0] wb_data,
        input logic sb_set, input logic [AW-1:0] sb_addr,
        input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
        input logic [DW-1:0] e_rd0, input logic [DW-1:0] e_rd1,
        input logic e_rbusy0, input logic [AW:0] e_cnt);
        vec_t v;
        v.wa_en = wa_en;   v.wa_addr = wa_addr; v.wa_be = wa_be; v.wa_data = wa_data;
        v.wb_en = wb_en;   v.wb_addr = wb_addr; v.wb_data = wb_data;
        v.sb_set = sb_set; v.sb_addr = sb_addr;
        v.ra0 = ra0;       v.ra1 = ra1;
        v.e_rd0 = e_rd0;   v.e_rd1 = e_rd1;     v.e_rbusy0 = e_rbusy0; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.wa_en = 1'b0; bus.wa_addr = '0; bus.wa_be = '0; bus.wa_data = '0;
        bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.sb_set = 1'b0; bus.sb_addr = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // watchdog: nothing here waits on the DUT, but never let the run hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        vec_t v;

        idle_inputs();
        bus.ra0 = 5'd5; bus.ra1 = 5'd5; bus.ra2 = 5'd5;

        // ---- reset: outputs forced to zero even with a bypassing write ----
        repeat (2) @(posedge clk);
        #1;
        bus.wa_en = 1'b1; bus.wa_addr = 5'd5; bus.wa_be = 4'hF; bus.wa_data = 32'hFFFF_FFFF;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234_5678;
        #2;
        check("rst.rd0", bus.rd0, 32'h0);
        check("rst.rbusy0", bus.rbusy0, 1'b0);
        check("rst.busy_cnt", bus.busy_cnt, 6'd0);
        check("rst.busy_any", bus.busy_any, 1'b0);
        idle_inputs();
        next_cycle();
        rst = 1'b0;

        // ---- all registers read zero on all ports after reset ----
        for (int i = 0; i < 32; i++) begin
            bus.ra0 = AW'(i); bus.ra1 = AW'(i); bus.ra2 = AW'(i);
            #1;
            check($sformatf("init.rd0[%0d]", i), bus.rd0, 32'h0);
            check($sformatf("init.rd1[%0d]", i), bus.rd1, 32'h0);
            check($sformatf("init.rd2[%0d]", i), bus.rd2, 32'h0);
            check($sformatf("init.rbusy2[%0d]", i), bus.rbusy2, 1'b0);
        end
        check("init.busy_cnt", bus.busy_cnt, 6'd0);
        check("init.busy_any", bus.busy_any, 1'b0);
        next_cycle();

        // ---- vector table (e_cnt is the registered count seen in that cycle) ----
        //                wa  addr  be    wa_data         wb  addr  wb_data         sb  addr  ra0   ra1   e_rd0           e_rd1           rb  cnt
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          0, 5'd0,  32'h0,          0, 5'd0,  5'd5, 5'd7, 32'h0,          32'h0,          0, 6'd0));
        vecs.push_back(mk(1, 5'd5,  4'hF, 32'hDEADBEEF,   0, 5'd0,  32'h0,          0, 5'd0,  5'd5, 5'd5, 32'hDEADBEEF,   32'hDEADBEEF,   0, 6'd0));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          0, 5'd0,  32'h0,          0, 5'd0,  5'd5, 5'd5, 32'hDEADBEEF,   32'hDEADBEEF,   0, 6'd0));
        vecs.push_back(mk(1, 5'd5,  4'h2, 32'h0000AA00,   0, 5'd0,  32'h0,          0, 5'd0,  5'd5, 5'd5, 32'hDEADAAEF,   32'hDEADAAEF,   0, 6'd0));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          0, 5'd0,  32'h0,          0, 5'd0,  5'd5, 5'd5, 32'hDEADAAEF,   32'hDEADAAEF,   0, 6'd0));
        vecs.push_back(mk(1, 5'd5,  4'h0, 32'hFFFFFFFF,   0, 5'd0,  32'h0,          0, 5'd0,  5'd5, 5'd5, 32'hDEADAAEF,   32'hDEADAAEF,   0, 6'd0));
        vecs.push_back(mk(1, 5'd7,  4'h1, 32'h000000FF,   1, 5'd7,  32'h11223344,   0, 5'd0,  5'd7, 5'd5, 32'h112233FF,   32'hDEADAAEF,   0, 6'd0));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          0, 5'd0,  32'h0,          0, 5'd0,  5'd7, 5'd7, 32'h112233FF,   32'h112233FF,   0, 6'd0));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          0, 5'd0,  32'h0,          1, 5'd9,  5'd9, 5'd9, 32'h0,          32'h0,          0, 6'd0));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          0, 5'd0,  32'h0,          0, 5'd0,  5'd9, 5'd9, 32'h0,          32'h0,          1, 6'd1));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          0, 5'd0,  32'h0,          1, 5'd9,  5'd9, 5'd9, 32'h0,          32'h0,          1, 6'd1));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          0, 5'd0,  32'h0,          0, 5'd0,  5'd9, 5'd9, 32'h0,          32'h0,          1, 6'd1));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          1, 5'd9,  32'h42,         0, 5'd0,  5'd9, 5'd9, 32'h42,         32'h42,         0, 6'd1));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          0, 5'd0,  32'h0,          0, 5'd0,  5'd9, 5'd9, 32'h42,         32'h42,         0, 6'd0));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          1, 5'd10, 32'h55,         1, 5'd10, 5'd10,5'd10,32'h55,         32'h55,         0, 6'd0));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          0, 5'd0,  32'h0,          0, 5'd0,  5'd10,5'd10,32'h55,         32'h55,         1, 6'd1));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          1, 5'd10, 32'h66,         1, 5'd11, 5'd10,5'd9, 32'h66,         32'h42,         0, 6'd1));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          0, 5'd0,  32'h0,          0, 5'd0,  5'd11,5'd10,32'h0,          32'h66,         1, 6'd1));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          1, 5'd12, 32'h77,         0, 5'd0,  5'd12,5'd12,32'h77,         32'h77,         0, 6'd1));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          0, 5'd0,  32'h0,          0, 5'd0,  5'd12,5'd12,32'h77,         32'h77,         0, 6'd1));
        vecs.push_back(mk(1, 5'd0,  4'hF, 32'hFFFFFFFF,   0, 5'd0,  32'h0,          1, 5'd0,  5'd0, 5'd0, 32'h0,          32'h0,          0, 6'd1));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          1, 5'd0,  32'h12345678,   0, 5'd0,  5'd0, 5'd0, 32'h0,          32'h0,          0, 6'd1));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          0, 5'd0,  32'h0,          0, 5'd0,  5'd0, 5'd0, 32'h0,          32'h0,          0, 6'd1));
        vecs.push_back(mk(1, 5'd13, 4'hC, 32'hAABB0000,   1, 5'd13, 32'h11223344,   0, 5'd0,  5'd13,5'd13,32'hAABB3344,   32'hAABB3344,   0, 6'd1));
        vecs.push_back(mk(0, 5'd0,  4'h0, 32'h0,          0, 5'd0,  32'h0,          0, 5'd0,  5'd13,5'd12,32'hAABB3344,   32'h77,         0, 6'd1));

        foreach (vecs[i]) begin
            v = vecs[i];
            bus.wa_en = v.wa_en;   bus.wa_addr = v.wa_addr; bus.wa_be = v.wa_be; bus.wa_data = v.wa_data;
            bus.wb_en = v.wb_en;   bus.wb_addr = v.wb_addr; bus.wb_data = v.wb_data;
            bus.sb_set = v.sb_set; bus.sb_addr = v.sb_addr;
            bus.ra0 = v.ra0; bus.ra1 = v.ra1; bus.ra2 = v.ra0;
            e.rd0 = v.e_rd0; e.rd1 = v.e_rd1; e.rbusy0 = v.e_rbusy0; e.cnt = v.e_cnt;
            sb_q.push_back(e);
            #3;
            e = sb_q.pop_front();
            check($sformatf("v%0d.rd0", i), bus.rd0, e.rd0);
            check($sformatf("v%0d.rd1", i), bus.rd1, e.rd1);
            check($sformatf("v%0d.rd2", i), bus.rd2, e.rd0);
            check($sformatf("v%0d.rbusy0", i), bus.rbusy0, e.rbusy0);
            check($sformatf("v%0d.busy_cnt", i), bus.busy_cnt, e.cnt);
            check($sformatf("v%0d.busy_any", i), bus.busy_any, e.cnt != 0);
            next_cycle();
        end
        idle_inputs();

        // ---- mark every register busy: count saturates at DEPTH-1 ----
        for (int i = 1; i < 32; i++) begin
            bus.sb_set = 1'b1; bus.sb_addr = AW'(i);
            next_cycle();
        end
        bus.sb_addr = 5'd0;                 // ignored: hardwired zero
        next_cycle();
        bus.sb_addr = 5'd31;                // already busy
        next_cycle();
        idle_inputs();
        #1;
        check("sat.busy_cnt", bus.busy_cnt, 6'd31);
        check("sat.busy_any", bus.busy_any, 1'b1);
        bus.ra0 = 5'd31; bus.ra1 = 5'd0;
        #1;
        check("sat.rbusy0", bus.rbusy0, 1'b1);
        check("sat.rbusy1_zero", bus.rbusy1, 1'b0);
        next_cycle();

        // ---- reset asserted during a write to reg 3 ----
        bus.wa_en = 1'b1; bus.wa_addr = 5'd3; bus.wa_be = 4'hF; bus.wa_data = 32'hCAFE_F00D;
        bus.ra0 = 5'd3; bus.ra1 = 5'd11;
        #2;
        check("mrst.pre_bypass", bus.rd0, 32'hCAFE_F00D);
        next_cycle();
        idle_inputs();
        #1;
        check("mrst.pre_stored", bus.rd0, 32'hCAFE_F00D);
        next_cycle();
        bus.wa_en = 1'b1; bus.wa_addr = 5'd3; bus.wa_be = 4'hF; bus.wa_data = 32'h1234_5678;
        bus.sb_set = 1'b1; bus.sb_addr = 5'd3;
        #1;
        rst = 1'b1;
        #1;
        check("mrst.rd0", bus.rd0, 32'h0);
        check("mrst.rbusy1", bus.rbusy1, 1'b0);
        check("mrst.busy_cnt", bus.busy_cnt, 6'd0);
        check("mrst.busy_any", bus.busy_any, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        #2;
        check("mrst.reg3", bus.rd0, 32'h0);
        check("mrst.rbusy0", bus.rbusy0, 1'b0);
        check("mrst.rbusy1_after", bus.rbusy1, 1'b0);
        check("mrst.cnt_after", bus.busy_cnt, 6'd0);
        next_cycle();
        bus.sb_set = 1'b1; bus.sb_addr = 5'd4;
        next_cycle();
        idle_inputs();
        #1;
        check("mrst.cnt_restart", bus.busy_cnt, 6'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
